// File: rtl/icb_master_dma_if.sv
// ICB command/response bundle between the DMA initiator and the system bus.
interface icb_master_dma_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_read;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/icb_master_dma.sv
// Single-outstanding ICB initiator moving word blocks between system memory
// and local SRAM. Load: ICB read -> SRAM write. Store: SRAM read -> ICB write.
module icb_master_dma (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [31:0]      ext_addr,
  input  logic [12:0]      loc_addr,
  input  logic [12:0]      len,
  output logic             busy,
  output logic             done,
  output logic             err,
  icb_master_dma_if.master icb,
  output logic [31:0]      sram_wr_data,
  output logic [12:0]      sram_wr_addr,
  output logic             sram_wr_en,
  input  logic [31:0]      sram_rd_data,
  output logic [12:0]      sram_rd_addr,
  output logic             sram_rd_en
);

  typedef enum logic [2:0] {IDLE, SRD, SCAP, CMD, RSP, DONE} state_t;

  state_t      state_reg, state_next;
  logic        dir_reg, dir_next;
  logic [31:0] ext_reg, ext_next;
  logic [12:0] loc_reg, loc_next;
  logic [12:0] len_reg, len_next;
  logic [12:0] idx_reg, idx_next;
  logic [31:0] wdata_reg, wdata_next;
  logic        err_reg, err_next;
  logic        wr_en_reg, wr_en_next;
  logic [12:0] wr_addr_reg, wr_addr_next;
  logic [31:0] wr_data_reg, wr_data_next;

  // Current SRAM word address; wraps naturally at 13 bits.
  logic [12:0] loc_idx;
  logic        last_word;
  assign loc_idx   = loc_reg + idx_reg;
  assign last_word = (idx_reg == len_reg - 13'd1);

  // State and datapath registers; async reset returns everything to zero/IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      dir_reg     <= 1'b0;
      ext_reg     <= 32'd0;
      loc_reg     <= 13'd0;
      len_reg     <= 13'd0;
      idx_reg     <= 13'd0;
      wdata_reg   <= 32'd0;
      err_reg     <= 1'b0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= 13'd0;
      wr_data_reg <= 32'd0;
    end else begin
      state_reg   <= state_next;
      dir_reg     <= dir_next;
      ext_reg     <= ext_next;
      loc_reg     <= loc_next;
      len_reg     <= len_next;
      idx_reg     <= idx_next;
      wdata_reg   <= wdata_next;
      err_reg     <= err_next;
      wr_en_reg   <= wr_en_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
    end
  end

  // Next-state and datapath update; SRAM write strobe defaults to a single pulse.
  always_comb begin
    state_next   = state_reg;
    dir_next     = dir_reg;
    ext_next     = ext_reg;
    loc_next     = loc_reg;
    len_next     = len_reg;
    idx_next     = idx_reg;
    wdata_next   = wdata_reg;
    err_next     = err_reg;
    wr_en_next   = 1'b0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          dir_next = dir;
          ext_next = ext_addr & 32'hFFFF_FFFC;
          loc_next = loc_addr;
          len_next = len;
          idx_next = 13'd0;
          err_next = 1'b0;
          if (len == 13'd0)
            state_next = DONE;
          else if (dir)
            state_next = SRD;
          else
            state_next = CMD;
        end
      end
      SRD: state_next = SCAP;
      SCAP: begin
        wdata_next = sram_rd_data;
        state_next = CMD;
      end
      CMD: begin
        if (icb.cmd_ready)
          state_next = RSP;
      end
      RSP: begin
        if (icb.rsp_valid) begin
          if (icb.rsp_err) begin
            err_next   = 1'b1;
            state_next = DONE;
          end else begin
            if (!dir_reg) begin
              wr_en_next   = 1'b1;
              wr_addr_next = loc_idx;
              wr_data_next = icb.rsp_rdata;
            end
            if (last_word) begin
              state_next = DONE;
            end else begin
              idx_next   = idx_reg + 13'd1;
              state_next = dir_reg ? SRD : CMD;
            end
          end
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy          = (state_reg != IDLE);
  assign done          = (state_reg == DONE);
  assign err           = err_reg;
  assign icb.cmd_valid = (state_reg == CMD);
  assign icb.cmd_read  = (state_reg == CMD) && !dir_reg;
  assign icb.cmd_addr  = ext_reg + {17'd0, idx_reg, 2'b00};
  assign icb.cmd_wdata = wdata_reg;
  assign icb.cmd_wmask = ((state_reg == CMD) && dir_reg) ? 4'hF : 4'h0;
  assign icb.rsp_ready = (state_reg == RSP);
  assign sram_rd_en    = (state_reg == SRD);
  assign sram_rd_addr  = loc_idx;
  assign sram_wr_en    = wr_en_reg;
  assign sram_wr_addr  = wr_addr_reg;
  assign sram_wr_data  = wr_data_reg;

endmodule

// File: tb/tb_icb_master_dma.sv
// Bench for icb_master_dma: bus/SRAM responder, transfer-level reference model
// (expected command and SRAM-write queues plus computed done cycle), and
// directed cases pinned by literal expectations followed by random transfers.
module tb_icb_master_dma;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        dir = 1'b0;
  logic [31:0] ext_addr = 32'd0;
  logic [12:0] loc_addr = 13'd0;
  logic [12:0] len = 13'd0;
  logic        busy, done, err;
  logic [31:0] sram_wr_data;
  logic [12:0] sram_wr_addr;
  logic        sram_wr_en;
  logic [31:0] sram_rd_data;
  logic [12:0] sram_rd_addr;
  logic        sram_rd_en;

  icb_master_dma_if icb();

  icb_master_dma dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir),
    .ext_addr(ext_addr), .loc_addr(loc_addr), .len(len),
    .busy(busy), .done(done), .err(err), .icb(icb.master),
    .sram_wr_data(sram_wr_data), .sram_wr_addr(sram_wr_addr), .sram_wr_en(sram_wr_en),
    .sram_rd_data(sram_rd_data), .sram_rd_addr(sram_rd_addr), .sram_rd_en(sram_rd_en)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic rd; logic [31:0] wdata; logic [3:0] wmask; } cmd_t;
  typedef struct { logic [12:0] addr; logic [31:0] data; } wr_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // transfer-level model
  cmd_t        exp_cmd[$];
  wr_t         exp_wr[$];
  int          start_cyc = -10;
  int          done_cyc = -10;
  bit          have_xfer = 1'b0;
  logic        prev_err = 1'b0;
  logic        new_err = 1'b0;
  bit          t_dir = 1'b0;
  logic [12:0] t_loc = 13'd0;
  int          err_at = -1;
  int          cmd_stall[64];
  int          rsp_stall[64];
  logic [31:0] rdata_arr[64];
  logic [31:0] sram_arr[8192];

  // responder state
  int          w = 0;
  int          cmd_wait = 0;
  int          rsp_wait = 0;
  bit          outstanding = 1'b0;
  bit          rd_pend = 1'b0;
  logic [12:0] rd_pend_addr = 13'd0;
  bit          done_seen = 1'b0;
  int          last_done = -1;

  // per-transfer logs for literal pins
  logic [31:0] log_addr[$];
  logic [31:0] log_wdata[$];
  logic [12:0] log_rd[$];
  logic [12:0] log_wr_addr[$];
  logic [31:0] log_wr_data[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process and bus/SRAM responder, all evaluated mid-cycle.
  always @(negedge clk) begin
    logic eb, ed, ee;
    cmd_t c;
    wr_t  wv;
    eb = (cyc > start_cyc) && (cyc <= done_cyc);
    ed = (cyc == done_cyc);
    if (!have_xfer)            ee = 1'b0;
    else if (cyc <= start_cyc) ee = prev_err;
    else if (cyc < done_cyc)   ee = 1'b0;
    else                       ee = new_err;
    chk("busy", 32'(busy), 32'(eb));
    chk("done", 32'(done), 32'(ed));
    chk("err", 32'(err), 32'(ee));

    // SRAM read port: data valid the cycle after the request, garbage otherwise
    if (rd_pend) sram_rd_data = sram_arr[rd_pend_addr];
    else         sram_rd_data = $urandom;
    rd_pend = sram_rd_en;
    rd_pend_addr = sram_rd_addr;
    if (sram_rd_en) begin
      chk("sram_rd_on_store", 32'(t_dir), 32'd1);
      chk("sram_rd_addr", 32'(sram_rd_addr), 32'(13'(32'(t_loc) + w)));
      log_rd.push_back(sram_rd_addr);
    end

    // SRAM write port
    if (sram_wr_en) begin
      if (exp_wr.size() == 0) begin
        total++; bad++;
        $display("FAIL sram_wr: got write %h@%h required none", sram_wr_data, sram_wr_addr);
      end else begin
        wv = exp_wr.pop_front();
        chk("sram_wr_addr", 32'(sram_wr_addr), 32'(wv.addr));
        chk("sram_wr_data", sram_wr_data, wv.data);
      end
      sram_arr[sram_wr_addr] = sram_wr_data;
      log_wr_addr.push_back(sram_wr_addr);
      log_wr_data.push_back(sram_wr_data);
    end

    // ICB responder
    if (icb.rsp_ready) begin
      chk("rsp_ready_outstanding", 32'(outstanding), 32'd1);
      icb.cmd_ready = 1'($urandom);
      if (rsp_wait >= rsp_stall[w[5:0]]) begin
        icb.rsp_valid = 1'b1;
        icb.rsp_rdata = rdata_arr[w[5:0]];
        icb.rsp_err   = (w == err_at);
        outstanding = 1'b0;
        w++;
      end else begin
        icb.rsp_valid = 1'b0;
        icb.rsp_rdata = $urandom;
        icb.rsp_err   = 1'($urandom);
        rsp_wait++;
      end
    end else if (icb.cmd_valid) begin
      chk("cmd_single_outstanding", 32'(outstanding), 32'd0);
      if (exp_cmd.size() == 0) begin
        total++; bad++;
        $display("FAIL cmd: got command addr %h required none", icb.cmd_addr);
        icb.cmd_ready = 1'b0;
        icb.rsp_valid = 1'b0;
      end else begin
        c = exp_cmd[0];
        chk("cmd_addr", icb.cmd_addr, c.addr);
        chk("cmd_read", 32'(icb.cmd_read), 32'(c.rd));
        chk("cmd_wmask", 32'(icb.cmd_wmask), 32'(c.wmask));
        if (!c.rd) chk("cmd_wdata", icb.cmd_wdata, c.wdata);
        if (cmd_wait >= cmd_stall[w[5:0]]) begin
          icb.cmd_ready = 1'b1;
          void'(exp_cmd.pop_front());
          log_addr.push_back(icb.cmd_addr);
          log_wdata.push_back(icb.cmd_wdata);
          outstanding = 1'b1;
          rsp_wait = 0;
          cmd_wait = 0;
          // an early response here must be ignored until the next cycle
          icb.rsp_valid = (rsp_stall[w[5:0]] == 0);
          icb.rsp_rdata = rdata_arr[w[5:0]];
          icb.rsp_err   = (w == err_at);
        end else begin
          icb.cmd_ready = 1'b0;
          cmd_wait++;
          icb.rsp_valid = 1'($urandom);
          icb.rsp_rdata = $urandom;
          icb.rsp_err   = 1'($urandom);
        end
      end
    end else begin
      icb.cmd_ready = 1'($urandom);
      icb.rsp_valid = 1'($urandom);
      icb.rsp_rdata = $urandom;
      icb.rsp_err   = 1'($urandom);
    end

    if (done) begin
      last_done = cyc;
      done_seen = 1'b1;
      chk("done_cmds_left", 32'(exp_cmd.size()), 32'd0);
      chk("done_wrs_left", 32'(exp_wr.size()), 32'd0);
    end
  end

  task automatic check_zero_outputs();
    chk("rst_ctrl", 32'({busy, done, err, icb.cmd_valid, icb.cmd_read, icb.cmd_wmask,
                         icb.rsp_ready, sram_wr_en, sram_rd_en}), 32'd0);
    chk("rst_cmd_addr", icb.cmd_addr, 32'd0);
    chk("rst_cmd_wdata", icb.cmd_wdata, 32'd0);
    chk("rst_sram_wr", sram_wr_data | 32'(sram_wr_addr), 32'd0);
    chk("rst_sram_rd_addr", 32'(sram_rd_addr), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    have_xfer = 1'b0;
    start_cyc = -10;
    done_cyc = -10;
    exp_cmd.delete();
    exp_wr.delete();
    outstanding = 1'b0;
    w = 0; cmd_wait = 0; rsp_wait = 0; err_at = -1;
    @(negedge clk);
    check_zero_outputs();
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_xfer(input bit d, input logic [31:0] ea, input logic [12:0] la,
                          input logic [12:0] ln, input int e_at, input int c_fix,
                          input int r_fix, input logic [31:0] rbase, input bit spur,
                          input int abort_after);
    int   lim, lat, budget;
    cmd_t c;
    wr_t  wv;
    for (int i = 0; i < 64; i++) begin
      cmd_stall[i] = (c_fix >= 0) ? c_fix : int'($urandom_range(0, 3));
      rsp_stall[i] = (r_fix >= 0) ? r_fix : int'($urandom_range(0, 3));
      rdata_arr[i] = (rbase != 0) ? rbase + 32'(i) : $urandom;
    end
    lim = (e_at >= 0 && e_at < int'(ln)) ? e_at + 1 : int'(ln);
    lat = 0;
    for (int i = 0; i < lim; i++) begin
      c.addr  = (ea & 32'hFFFF_FFFC) + 32'(4 * i);
      c.rd    = !d;
      c.wmask = d ? 4'hF : 4'h0;
      c.wdata = d ? sram_arr[13'(int'(la) + i)] : 32'd0;
      exp_cmd.push_back(c);
      if (!d && i != e_at) begin
        wv.addr = 13'(int'(la) + i);
        wv.data = rdata_arr[i];
        exp_wr.push_back(wv);
      end
      lat += (d ? 2 : 0) + 2 + cmd_stall[i] + rsp_stall[i];
    end
    log_addr.delete(); log_wdata.delete(); log_rd.delete();
    log_wr_addr.delete(); log_wr_data.delete();
    @(negedge clk);
    prev_err  = have_xfer ? new_err : 1'b0;
    new_err   = (e_at >= 0 && e_at < int'(ln));
    have_xfer = 1'b1;
    start_cyc = cyc;
    done_cyc  = cyc + lat + 1;
    err_at    = e_at;
    w = 0; cmd_wait = 0; rsp_wait = 0;
    t_dir = d; t_loc = la;
    done_seen = 1'b0;
    start = 1'b1; dir = d; ext_addr = ea; loc_addr = la; len = ln;
    @(negedge clk);
    start = 1'b0; dir = 1'($urandom); ext_addr = $urandom; loc_addr = 13'($urandom); len = 13'($urandom);
    if (abort_after > 0) begin
      repeat (abort_after) @(negedge clk);
      do_reset();
      $display("xfer dir=%0d ext=%h loc=%h len=%0d aborted by reset", d, ea, la, ln);
      return;
    end
    if (spur) begin
      while (cyc < done_cyc) begin
        @(negedge clk);
        if ($urandom_range(0, 2) == 0) begin
          start = 1'b1; dir = 1'($urandom); ext_addr = $urandom;
          loc_addr = 13'($urandom); len = 13'($urandom);
          @(negedge clk);
          start = 1'b0;
        end
      end
    end
    budget = lat + 40;
    while (!done_seen && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("done_seen", 32'(done_seen), 32'd1);
    $display("xfer dir=%0d ext=%h loc=%h len=%0d err_at=%0d start=%0d done=%0d",
             d, ea, la, ln, e_at, start_cyc, last_done);
    if (!done_seen) do_reset();
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) sram_arr[i] = $urandom;
    @(negedge clk);
    check_zero_outputs();
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // load, len 4, zero-wait
    run_xfer(1'b0, 32'h1000_0010, 13'h005, 13'd4, -1, 0, 0, 32'hA0, 1'b0, 0);
    chk("t1_addr0", log_addr[0], 32'h1000_0010);
    chk("t1_addr3", log_addr[3], 32'h1000_001C);
    chk("t1_wr_addr0", 32'(log_wr_addr[0]), 32'h005);
    chk("t1_wr_addr3", 32'(log_wr_addr[3]), 32'h008);
    chk("t1_wr_data0", log_wr_data[0], 32'hA0);
    chk("t1_wr_data3", log_wr_data[3], 32'hA3);
    chk("t1_latency", 32'(last_done - start_cyc), 32'd9);

    // store across SRAM wrap with command stalls
    sram_arr[13'h1FFF] = 32'h11; sram_arr[13'h000] = 32'h22; sram_arr[13'h001] = 32'h33;
    run_xfer(1'b1, 32'h2000_0000, 13'h1FFF, 13'd3, -1, 2, 0, 32'd0, 1'b0, 0);
    chk("t2_rd1", 32'(log_rd[1]), 32'h000);
    chk("t2_wdata0", log_wdata[0], 32'h11);
    chk("t2_wdata2", log_wdata[2], 32'h33);
    chk("t2_latency", 32'(last_done - start_cyc), 32'd19);

    // zero length
    run_xfer(1'b0, 32'h3000_0000, 13'h010, 13'd0, -1, 0, 0, 32'd0, 1'b0, 0);
    chk("t3_latency", 32'(last_done - start_cyc), 32'd1);
    chk("t3_activity", 32'(log_addr.size() + log_rd.size() + log_wr_addr.size()), 32'd0);

    // error response on word 2 of a load
    run_xfer(1'b0, 32'h4000_0000, 13'h100, 13'd4, 2, -1, -1, 32'd0, 1'b0, 0);
    chk("t4_cmd_count", 32'(log_addr.size()), 32'd3);
    chk("t4_wr_count", 32'(log_wr_addr.size()), 32'd2);
    chk("t4_err_sticky", 32'(err), 32'd1);
    run_xfer(1'b0, 32'h4000_0100, 13'h200, 13'd1, -1, 0, 0, 32'd0, 1'b0, 0);
    chk("t4_err_cleared", 32'(err), 32'd0);

    // ignored starts while busy, then reset in the middle of a store
    run_xfer(1'b1, 32'h5000_0000, 13'h300, 13'd5, -1, -1, -1, 32'd0, 1'b1, 0);
    run_xfer(1'b1, 32'h5000_1000, 13'h400, 13'd6, -1, 1, 1, 32'd0, 1'b0, 7);

    // ICB address wrap and low-bit masking
    run_xfer(1'b0, 32'hFFFF_FFFC, 13'h020, 13'd2, -1, 0, 0, 32'd0, 1'b0, 0);
    chk("t6_addr_wrap", log_addr[1], 32'h0000_0000);
    run_xfer(1'b0, 32'h1234_5673, 13'h030, 13'd1, -1, 0, 0, 32'd0, 1'b0, 0);
    chk("t6_addr_mask", log_addr[0], 32'h1234_5670);

    // random transfers
    for (int k = 0; k < 40; k++) begin
      bit          d;
      logic [12:0] ln, la;
      int          e_at;
      d  = 1'($urandom);
      ln = ($urandom_range(0, 9) == 0) ? 13'd0 : 13'($urandom_range(1, 12));
      la = ($urandom_range(0, 3) == 0) ? 13'($urandom_range(8185, 8191)) : 13'($urandom);
      e_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 12)) : -1;
      run_xfer(d, $urandom, la, ln, e_at, -1, -1, 32'd0, ($urandom_range(0, 3) == 0), 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
